data_mem_controller: RTL and testbench
======================================

# data_mem_controller

Responder for the data-memory requests that the single-cycle RISC-V core's control unit issues through MemRead/MemWrite. It accepts one word access per cycle from the core and posts writes into a one-entry write buffer. It forwards reads that hit the buffered write and otherwise runs a req/ack transaction against a variable-latency backing memory. While an access cannot complete, it holds the core with Stall.

## Interface
- ADDR_W, 32, byte address width from the core
- DATA_W, 32, data word width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  core load request (level, held while Stall=1)
- MemWrite  in  1  core store request (level, held while Stall=1)
- Addr  in  ADDR_W  byte address; Addr[1:0] ignored (word accesses only)
- WriteData  in  DATA_W  store data
- ReadData  out  DATA_W  load data, valid in the cycle a load completes (Stall=0)
- Stall  out  1  combinational; 1 = current core request not completed this cycle
- mem_req  out  1  registered backend request, held until mem_ack
- mem_we  out  1  registered, 1 = write transaction
- mem_addr  out  ADDR_W  registered word-aligned address (bits [1:0] = 0)
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  backend read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from backend

## Operation
- Write buffer (WB): valid, word address, data. It holds at most one posted store.
- FSM states:
  - IDLE: no backend transaction.
  - DRAIN: WB write outstanding.
  - READ: load outstanding.
  - RESP: registered load data presented.
- Request precedence: MemWrite beats MemRead. If both are high, the access is treated as a store and the read is ignored.
- Store, IDLE, WB empty: the store is captured into WB at the edge, with Stall=0. Next state is DRAIN. mem_req, mem_we, mem_addr, and mem_wdata are loaded from the new entry.
- Store, WB valid: Stall=1 until WB clears. The store is captured in the first IDLE cycle with WB empty.
- Load, WB valid, word address matches: ReadData = WB data and Stall=0 in the same cycle. This applies in IDLE or DRAIN. There is no backend access.
- Load, WB valid, address mismatch: Stall=1. WB must drain first (program order). The load is then handled as a miss.
- Load miss in IDLE with WB empty: Stall=1. Go to READ with mem_req=1, mem_we=0, mem_addr={Addr[ADDR_W-1:2],2'b00}.
- READ with mem_ack: register mem_rdata into rdata_q, drop mem_req, go to RESP.
- RESP: ReadData = rdata_q and Stall=0. The held load completes. Go to IDLE.
- DRAIN with mem_ack: clear WB valid, drop mem_req, go to IDLE.
- ReadData when no load completes: holds rdata_q.
- No request (MemRead=MemWrite=0): Stall=0.
- Reset: WB valid=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_q=0.
  - While rst=1: Stall=0 and ReadData=0.
  - Reset mid-transaction abandons the backend request (mem_req low next edge) and discards a pending WB entry. The backend must tolerate an abandoned request.
- mem_ack while mem_req=0: ignored.

## Timing
- Store to non-full WB: zero stall cycles (posted).
- Forwarded load: zero stall cycles.
- Load miss, WB empty, backend acks in the first cycle mem_req is high:
  - cycle 0: IDLE, Stall=1.
  - cycle 1: READ, mem_req=1, ack.
  - cycle 2: RESP, Stall=0.
  - Each additional backend wait cycle adds one stall cycle.
- Backend request rule: mem_req, mem_we, mem_addr, and mem_wdata stay stable from assertion through the mem_ack cycle. mem_req is low the cycle after ack. There is at least one idle cycle between transactions.
- Load behind a mismatching WB entry: drain latency plus the load-miss latency.

## Structure
- Package dmc_pkg holds:
  - state enum (IDLE, DRAIN, READ, RESP)
  - WORD_OFFSET = 2
  - a word-address compare helper
- Sub-module dmc_write_buffer holds the valid, address, and data registers and provides capture, clear, and hit outputs.
- The top level contains the FSM, the Stall/ReadData muxing, and the backend registers.

## Test plan
- Reset mid-DRAIN: store 0x11223344 @0x100; rst high before ack → mem_req=0 next edge, WB empty; a subsequent load @0x100 issues a backend read.
- Posted store, then forward: store 0xDEADBEEF @0x40 (Stall=0); next cycle load @0x42 → ReadData=0xDEADBEEF, Stall=0, no mem_req with mem_we=0.
- Load miss with 3-cycle backend latency: load @0x80, backend returns 0xCAFEF00D → Stall=1 for 5 cycles, ReadData=0xCAFEF00D in the first Stall=0 cycle; mem_addr=0x80.
- Ordering: store @0x10, then immediately load @0x20 → mem write @0x10 acks before mem_req with mem_we=0 @0x20 asserts.
- Back-to-back stores @0x0, then @0x4 with ack delay 2 → second store Stall=1 until WB clears, then captured; two backend writes in order with an idle cycle between.

Source files
------------

// File: rtl/dmc_pkg.sv
// Shared types and helpers for the data-memory controller.
package dmc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned WORD_OFFSET = 2;
  localparam int unsigned MAX_ADDR_W  = 64;

  // True when two byte addresses fall in the same word.
  function automatic logic same_word(input logic [MAX_ADDR_W-1:0] a,
                                     input logic [MAX_ADDR_W-1:0] b);
    return (a >> WORD_OFFSET) == (b >> WORD_OFFSET);
  endfunction

endpackage

// File: rtl/dmc_write_buffer.sv
// One-entry posted-store buffer with a combinational word-address hit.
module dmc_write_buffer
  import dmc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              hit_c
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      addr_q <= '0;
      data   <= '0;
    end else if (capture) begin
      valid  <= 1'b1;
      addr_q <= cap_addr;
      data   <= cap_data;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

  assign hit_c = valid && same_word(MAX_ADDR_W'(addr_q), MAX_ADDR_W'(lookup_addr));

endmodule

// File: rtl/data_mem_controller.sv
// Core-facing data-memory responder: posted stores, store-to-load forwarding,
// and a req/ack handshake to a variable-latency backing memory.
module data_mem_controller
  import dmc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q, state_d;
  logic              wb_valid, wb_hit_c, wb_capture, wb_clear;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              store_c, load_c, ack_c;
  logic [ADDR_W-1:0] addr_word;

  // Store wins when both strobes are high.
  assign store_c   = MemWrite;
  assign load_c    = MemRead & ~MemWrite;
  assign ack_c     = mem_ack & mem_req;
  assign addr_word = {Addr[ADDR_W-1:WORD_OFFSET], WORD_OFFSET'(0)};

  dmc_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wb (
    .clk         (clk),
    .rst         (rst),
    .capture     (wb_capture),
    .clear       (wb_clear),
    .cap_addr    (addr_word),
    .cap_data    (WriteData),
    .lookup_addr (Addr),
    .valid       (wb_valid),
    .data        (wb_data),
    .hit_c       (wb_hit_c)
  );

  // Next-state, backend request and core-side Stall/ReadData.
  always_comb begin
    state_d    = state_q;
    req_d      = mem_req;
    we_d       = mem_we;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    rdata_d    = rdata_q;
    wb_capture = 1'b0;
    wb_clear   = 1'b0;
    Stall      = 1'b0;
    ReadData   = rdata_q;

    case (state_q)
      IDLE: begin
        if (store_c) begin
          if (!wb_valid) begin
            wb_capture = 1'b1;
            state_d    = DRAIN;
            req_d      = 1'b1;
            we_d       = 1'b1;
            addr_d     = addr_word;
            wdata_d    = WriteData;
          end else begin
            Stall = 1'b1;
          end
        end else if (load_c) begin
          if (wb_hit_c) begin
            ReadData = wb_data;
          end else if (wb_valid) begin
            Stall = 1'b1;
          end else begin
            Stall   = 1'b1;
            state_d = READ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = addr_word;
          end
        end
      end

      DRAIN: begin
        if (store_c) begin
          Stall = 1'b1;
        end else if (load_c) begin
          if (wb_hit_c) begin
            ReadData = wb_data;
          end else begin
            Stall = 1'b1;
          end
        end
        if (ack_c) begin
          wb_clear = 1'b1;
          req_d    = 1'b0;
          state_d  = IDLE;
        end
      end

      READ: begin
        Stall = MemRead | MemWrite;
        if (ack_c) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      Stall    = 1'b0;
      ReadData = '0;
    end
  end

  // State and backend request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: directed scenarios plus random traffic
// checked against a word-level memory model and a backend protocol monitor.
module tb_data_mem_controller;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              MemRead, MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          start;
    int          ack;
  } tx_t;

  tx_t         txq[$];
  logic [31:0] bmem  [logic [31:0]];
  logic [31:0] model [logic [31:0]];

  data_mem_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] bval(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mval(input logic [31:0] a);
    return model.exists(word(a)) ? model[word(a)] : init_val(word(a));
  endfunction

  function automatic int count_reads();
    int n = 0;
    foreach (txq[i]) if (!txq[i].we) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing memory: acks after cur_lat extra cycles, monitors the handshake.
  logic busy = 1'b0, ack_prev = 1'b0;
  int   wcnt = 0, cur_lat = 0, last_ack = -10;
  tx_t  cur;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst) begin
      busy = 1'b0; ack_prev = 1'b0; wcnt = 0;
    end else if (ack_prev) begin
      chk("req_drop_after_ack", 64'(mem_req), 64'(0));
      ack_prev = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1; wcnt = 0; cur_lat = lat;
        cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wdata; cur.start = cyc;
        chk("idle_gap", 64'((cyc - last_ack >= 2) ? 1 : 0), 64'(1));
        chk("addr_align", 64'(mem_addr[1:0]), 64'(0));
      end
      if (wcnt >= cur_lat) begin
        chk("req_stable", 64'((mem_we === cur.we && mem_addr === cur.addr &&
                               mem_wdata === cur.data) ? 1 : 0), 64'(1));
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else        mem_rdata = bval(mem_addr);
        mem_ack = 1'b1; ack_prev = 1'b1; busy = 1'b0;
        cur.ack = cyc; last_ack = cyc;
        txq.push_back(cur);
      end else begin
        wcnt++;
      end
    end
  end

  // One core access, held until Stall drops; ends one cycle later at posedge+1.
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                    output int stalls, output logic [31:0] rd);
    logic done = 1'b0;
    MemWrite = w; MemRead = r; Addr = a; WriteData = d;
    stalls = 0; rd = '0;
    while (!done && stalls < 300) begin
      @(negedge clk);
      if (!Stall) begin rd = ReadData; done = 1'b1; end
      else stalls++;
    end
    chk("op_complete", 64'(done), 64'(1));
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    if (w) model[word(a)] = d;
  endtask

  task automatic store_chk(input string tag, input logic both, input logic [31:0] a,
                           input logic [31:0] d, input int exp_st);
    int st; logic [31:0] rd;
    op(1'b1, both, a, d, st, rd);
    if (exp_st >= 0) chk({tag, "_stall"}, 64'(st), 64'(exp_st));
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input int exp_st);
    int st; logic [31:0] rd; logic [31:0] exp;
    exp = mval(a);
    op(1'b0, 1'b1, a, 32'h0, st, rd);
    chk({tag, "_data"}, 64'(rd), 64'(exp));
    if (exp_st >= 0) chk({tag, "_stall"}, 64'(st), 64'(exp_st));
  endtask

  task automatic wait_idle();
    int cnt = 0, n = 0;
    while (cnt < 2 && n < 100) begin
      @(negedge clk); n++;
      if (!mem_req) cnt++; else cnt = 0;
    end
    chk("idle_reached", 64'((cnt >= 2) ? 1 : 0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, nr;
    logic [31:0] a, d;
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;

    // Reset behaviour
    @(negedge clk);
    chk("rst_stall", 64'(Stall), 64'(0));
    chk("rst_rdata", 64'(ReadData), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    @(posedge clk); #1;

    // Posted store, then forwarded load
    lat = 2;
    nr = count_reads();
    store_chk("post", 1'b0, 32'h40, 32'hDEADBEEF, 0);
    load_chk("fwd", 32'h42, 0);
    wait_idle();
    chk("fwd_no_read", 64'(count_reads()), 64'(nr));

    // Load miss, three backend wait cycles
    bmem[32'h80] = 32'hCAFEF00D; model[32'h80] = 32'hCAFEF00D;
    lat = 3;
    load_chk("miss", 32'h80, 5);
    chk("miss_addr", 64'(txq[$].addr), 64'(32'h80));
    chk("miss_we", 64'(txq[$].we), 64'(0));

    // Program order: load behind a mismatching buffered store
    wait_idle();
    lat = 2;
    store_chk("ord_st", 1'b0, 32'h10, 32'h13579BDF, 0);
    load_chk("ord_ld", 32'h20, 7);
    n0 = txq.size();
    if (n0 >= 2) begin
      chk("ord_first", 64'({txq[n0-2].we, txq[n0-2].addr}), 64'({1'b1, 32'h10}));
      chk("ord_second", 64'({txq[n0-1].we, txq[n0-1].addr}), 64'({1'b0, 32'h20}));
      chk("ord_after_ack", 64'((txq[n0-1].start > txq[n0-2].ack) ? 1 : 0), 64'(1));
    end

    // Back-to-back stores
    wait_idle();
    lat = 2;
    n0 = txq.size();
    store_chk("b2b_1", 1'b0, 32'h0, 32'hA0A0A0A0, 0);
    store_chk("b2b_2", 1'b0, 32'h4, 32'hB1B1B1B1, 3);
    wait_idle();
    chk("b2b_count", 64'(txq.size()), 64'(n0 + 2));
    if (txq.size() == n0 + 2) begin
      chk("b2b_w1", 64'({txq[n0].we, txq[n0].addr, txq[n0].data[30:0]}),
          64'({1'b1, 32'h0, 31'h20A0A0A0}));
      chk("b2b_w2", 64'({txq[n0+1].we, txq[n0+1].addr, txq[n0+1].data[30:0]}),
          64'({1'b1, 32'h4, 31'h31B1B1B1}));
      chk("b2b_gap", 64'((txq[n0+1].start - txq[n0].ack >= 2) ? 1 : 0), 64'(1));
    end

    // Reset while a buffered store is draining
    lat = 5;
    store_chk("rst_st", 1'b0, 32'h100, 32'h11223344, 0);
    chk("rst_req_live", 64'(mem_req), 64'(1));
    rst = 1'b1; MemRead = 1'b1; Addr = 32'h100;
    @(negedge clk);
    chk("rst_mid_stall", 64'(Stall), 64'(0));
    chk("rst_mid_rdata", 64'(ReadData), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", 64'(mem_req), 64'(0));
    model = bmem;
    @(posedge clk); #1;
    lat = 1;
    nr = count_reads();
    load_chk("rst_ld", 32'h100, 3);
    chk("rst_ld_read", 64'(count_reads()), 64'(nr + 1));

    // Random traffic against the memory model
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(0, 3));
      a    = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d    = $urandom;
      case (kind)
        0: store_chk("rnd_st", 1'b0, a, d, -1);
        1: load_chk("rnd_ld", a, -1);
        2: store_chk("rnd_both", 1'b1, a, d, -1);
        default: begin
          @(negedge clk);
          chk("rnd_idle_stall", 64'(Stall), 64'(0));
          @(posedge clk); #1;
        end
      endcase
    end
    wait_idle();
    for (int w = 0; w < 16; w++) load_chk("final_ld", 32'(w) << 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
